axi_dma_copy_engine: RTL and testbench

Synthesizable AXI4 memory-to-memory copy engine. It replaces the behavioural DMA master model on NoC master port M1, typically moving weight tiles from SRAM (S1) into MRAM (S0) or back. A software-visible start/done interface drives it. It splits each transfer into INCR bursts of at most BURST_LEN beats, staging each read burst in a local FIFO before writing it out.

---
 rtl/axi_dma_copy_engine_pkg.sv | 9 +
 rtl/axi_dma_copy_engine_if.sv | 18 +
 rtl/dma_burst_fifo.sv | 31 +++
 rtl/axi_dma_copy_engine.sv | 126 ++++++++++++
 tb/tb_axi_dma_copy_engine.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/axi_dma_copy_engine_pkg.sv
// dma_pkg: FSM states, AXI response/burst constants and burst sizing helper for the copy engine
package dma_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, FINISH} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] INCR = 2'b01;
  function automatic logic [15:0] burst_beats(input logic [15:0] rem, input logic [15:0] max_beats);
    return rem > max_beats ? max_beats : rem;
  endfunction
endpackage

// File: rtl/axi_dma_copy_engine_if.sv
// axi_dma_copy_engine_if: AXI4 AW/W/B/AR/R bundle; master = copy engine, slave = NoC port
interface axi_dma_copy_engine_if #(parameter int ID_W = 4, parameter int ADDR_W = 32, parameter int DATA_W = 64);
  logic [ID_W-1:0] awid, bid, arid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [DATA_W-1:0] wdata, rdata;
  logic [1:0] bresp, rresp;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rlast, rready;
  modport master(
    output awid, awaddr, awlen, awvalid, wdata, wlast, wvalid, bready, arid, araddr, arlen, arvalid, rready,
    input awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid, rlast
  );
  modport slave(
    input awid, awaddr, awlen, awvalid, wdata, wlast, wvalid, bready, arid, araddr, arlen, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rvalid, rlast
  );
endinterface

// File: rtl/dma_burst_fifo.sv
// dma_burst_fifo: single-clock FIFO (push/pop/full/empty, din/dout) staging one read burst for writing
module dma_burst_fifo #(parameter int DEPTH = 16, parameter int WIDTH = 64) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH) + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = wp == {~rp[PW-1], rp[PW-2:0]};
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp[PW-2:0]];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + PW'(do_push);
      rp <= rp + PW'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wp[PW-2:0]] <= din;
endmodule

// File: rtl/axi_dma_copy_engine.sv
// axi_dma_copy_engine: start/done memory-to-memory AXI4 copier (clk, rst_n, start/src/dst/len in, busy/done/error out, AXI master m)
module axi_dma_copy_engine
  import dma_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int BURST_LEN      = 16,
  parameter int DMA_ID         = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [AXI_ADDR_WIDTH-1:0] src_addr,
  input  logic [AXI_ADDR_WIDTH-1:0] dst_addr,
  input  logic [15:0]               len_words,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  axi_dma_copy_engine_if.master     m
);
  localparam int LSB = $clog2(AXI_DATA_WIDTH / 8);
  state_t st;
  logic [AXI_ADDR_WIDTH-1:0] src_q, dst_q, step;
  logic [15:0] rem, beats, rem_n;
  logic [7:0] len_q, wcnt;
  logic [AXI_DATA_WIDTH-1:0] head;
  logic ar_v, aw_v, b_r, full, empty, misal, bad_b, fin, unused_ok;
  assign beats = 16'(len_q) + 16'd1;
  assign rem_n = rem - beats;
  assign step = AXI_ADDR_WIDTH'(beats) << LSB;
  assign misal = |src_addr[LSB-1:0] || |dst_addr[LSB-1:0];
  assign bad_b = m.bresp != RESP_OKAY;
  assign fin = rem_n == '0 || error || bad_b;
  assign busy = st != IDLE;
  assign m.arvalid = ar_v;
  assign m.awvalid = aw_v;
  assign m.bready = b_r;
  assign m.arid = AXI_ID_WIDTH'(DMA_ID);
  assign m.awid = AXI_ID_WIDTH'(DMA_ID);
  assign m.araddr = src_q;
  assign m.awaddr = dst_q;
  assign m.arlen = len_q;
  assign m.awlen = len_q;
  assign m.rready = st == RD_DATA && !full;
  assign m.wvalid = st == WR_DATA && !empty;
  assign m.wlast = m.wvalid && wcnt == len_q;
  assign m.wdata = m.wvalid ? head : '0;
  assign unused_ok = ^{m.rid, m.bid};
  dma_burst_fifo #(.DEPTH(BURST_LEN), .WIDTH(AXI_DATA_WIDTH)) u_fifo (
    .clk,
    .rst_n,
    .push(m.rvalid && m.rready),
    .pop(m.wvalid && m.wready),
    .din(m.rdata),
    .dout(head),
    .full,
    .empty
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      rem <= '0;
      len_q <= '0;
      wcnt <= '0;
      ar_v <= 1'b0;
      aw_v <= 1'b0;
      b_r <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      case (st)
        IDLE: if (start) begin
          error <= misal;
          src_q <= src_addr;
          dst_q <= dst_addr;
          rem <= len_words;
          len_q <= 8'(burst_beats(len_words, 16'(BURST_LEN)) - 16'd1);
          ar_v <= !misal && len_words != '0;
          st <= misal || len_words == '0 ? FINISH : RD_ADDR;
        end
        RD_ADDR: if (m.arready) begin
          ar_v <= 1'b0;
          st <= RD_DATA;
        end
        RD_DATA: if (m.rvalid && m.rready) begin
          if (m.rresp != RESP_OKAY) error <= 1'b1;
          if (m.rlast) begin
            aw_v <= 1'b1;
            st <= WR_ADDR;
          end
        end
        WR_ADDR: if (m.awready) begin
          aw_v <= 1'b0;
          wcnt <= '0;
          st <= WR_DATA;
        end
        WR_DATA: if (m.wvalid && m.wready) begin
          wcnt <= wcnt + 8'd1;
          if (m.wlast) begin
            b_r <= 1'b1;
            st <= WR_RESP;
          end
        end
        WR_RESP: if (m.bvalid) begin
          b_r <= 1'b0;
          src_q <= src_q + step;
          dst_q <= dst_q + step;
          rem <= rem_n;
          error <= error || bad_b;
          len_q <= 8'(burst_beats(rem_n, 16'(BURST_LEN)) - 16'd1);
          done <= fin;
          ar_v <= !fin;
          st <= fin ? FINISH : RD_ADDR;
        end
        FINISH: begin
          done <= !done;
          if (done) st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_dma_copy_engine.sv
// tb_axi_dma_copy_engine: table-driven and random copies against a memory-level model of the copy engine
module tb_axi_dma_copy_engine;
  typedef struct packed {logic [31:0] a; logic [7:0] l;} req_t;
  typedef struct {logic [31:0] src; logic [31:0] dst; int len; bit stall; int inj; bit exp_err; int exp_b;} vec_t;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] src_addr = 0, dst_addr = 0;
  logic [15:0] len_words = 0;
  logic busy, done, error;
  int checks = 0, failures = 0;
  bit stall = 0;
  int inj_burst = 0, xfer_id = 0;
  logic [63:0] smem [logic [31:0]];
  logic [63:0] wmem [logic [31:0]];
  req_t ar_log[$], aw_log[$];
  vec_t vecs[$];
  axi_dma_copy_engine_if #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) bus ();
  axi_dma_copy_engine #(.AXI_ID_WIDTH(4), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .BURST_LEN(16), .DMA_ID(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len_words(len_words), .busy(busy), .done(done), .error(error), .m(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask
  initial begin
    int seen = 0, rd_left = 0, rd_burst = 0, rd_beat = 0, wr_beat = 0, wr_len = 0;
    logic [31:0] rd_a = 0, wr_a = 0, p_ara = 0, p_awa = 0;
    logic [63:0] p_wd = 0;
    bit b_pend = 0, r_hold = 0, b_hold = 0, exp_aw = 0, exp_nx = 0, p_ar = 0, p_aw = 0, p_w = 0;
    {bus.arready, bus.awready, bus.wready, bus.bvalid, bus.rvalid, bus.rlast} = '0;
    {bus.bid, bus.rid, bus.bresp, bus.rresp, bus.rdata} = '0;
    forever begin
      @(negedge clk);
      if (seen != xfer_id) begin
        seen = xfer_id;
        ar_log.delete();
        aw_log.delete();
        wmem.delete();
        rd_burst = 0;
      end
      if (!rst_n) begin
        rd_left = 0; b_pend = 0; r_hold = 0; b_hold = 0; exp_aw = 0; exp_nx = 0;
        p_ar = 0; p_aw = 0; p_w = 0;
        bus.rvalid = 0; bus.bvalid = 0; bus.rlast = 0;
        continue;
      end
      if (p_ar) chk("ar_hold", {bus.arvalid, bus.araddr}, {1'b1, p_ara});
      if (p_aw) chk("aw_hold", {bus.awvalid, bus.awaddr}, {1'b1, p_awa});
      if (p_w) chk("w_hold", {bus.wvalid, bus.wdata}, {1'b1, p_wd});
      if (exp_aw) chk("aw_after_rlast", bus.awvalid, 1);
      if (exp_nx) chk("next_after_b", bus.arvalid | done, 1);
      exp_aw = 0;
      exp_nx = 0;
      bus.arready = !stall || $urandom_range(0, 1) == 1;
      bus.awready = !stall || $urandom_range(0, 1) == 1;
      bus.wready = !stall || $urandom_range(0, 1) == 1;
      bus.bvalid = b_pend && (b_hold || !stall || $urandom_range(0, 1) == 1);
      bus.bresp = 2'b00;
      b_hold = bus.bvalid && !bus.bready;
      if (bus.bvalid && bus.bready) begin
        b_pend = 0;
        exp_nx = 1;
      end
      if (bus.wvalid && bus.wready) begin
        chk("wlast", bus.wlast, wr_beat == wr_len);
        wmem[wr_a] = bus.wdata;
        wr_a += 8;
        wr_beat++;
        if (bus.wlast) b_pend = 1;
      end
      if (bus.awvalid && bus.awready) begin
        aw_log.push_back(req_t'{a: bus.awaddr, l: bus.awlen});
        wr_a = bus.awaddr;
        wr_len = int'(bus.awlen);
        wr_beat = 0;
      end
      if (rd_left > 0) begin
        bus.rvalid = r_hold || !stall || $urandom_range(0, 1) == 1;
        if (!smem.exists(rd_a)) smem[rd_a] = {$urandom, $urandom};
        bus.rdata = smem[rd_a];
        bus.rresp = (rd_burst == inj_burst && rd_beat == 2) ? 2'b10 : 2'b00;
        bus.rlast = rd_left == 1;
      end else begin
        bus.rvalid = 0;
        bus.rlast = 0;
      end
      r_hold = bus.rvalid && !bus.rready;
      if (bus.rvalid && bus.rready) begin
        if (bus.rlast) exp_aw = 1;
        rd_a += 8;
        rd_left--;
        rd_beat++;
      end
      if (bus.arvalid && bus.arready) begin
        ar_log.push_back(req_t'{a: bus.araddr, l: bus.arlen});
        rd_a = bus.araddr;
        rd_left = int'(bus.arlen) + 1;
        rd_beat = 0;
        rd_burst++;
      end
      p_ar = bus.arvalid && !bus.arready;
      p_ara = bus.araddr;
      p_aw = bus.awvalid && !bus.awready;
      p_awa = bus.awaddr;
      p_w = bus.wvalid && !bus.wready;
      p_wd = bus.wdata;
    end
  end
  task automatic run_xfer(input vec_t v, input string tag);
    int n_done = 0, rem, b, bad, nb;
    logic [31:0] sa, da;
    stall = v.stall;
    inj_burst = v.inj;
    xfer_id++;
    @(negedge clk);
    src_addr = v.src; dst_addr = v.dst; len_words = 16'(v.len); start = 1;
    @(negedge clk);
    start = 0;
    chk({tag, " busy_arvalid_n1"}, {busy, bus.arvalid}, 2'b11);
    for (int w = 0; w < 4000 && !done; w++) @(negedge clk);
    chk({tag, " done"}, done, 1);
    chk({tag, " error"}, error, v.exp_err);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk({tag, " single_done_idle"}, {n_done[7:0], busy}, 0);
    chk({tag, " ar_count"}, ar_log.size(), v.exp_b);
    chk({tag, " aw_count"}, aw_log.size(), v.exp_b);
    nb = v.inj != 0 ? v.inj : 1 << 20;
    rem = v.len; sa = v.src; da = v.dst;
    for (int k = 0; rem > 0 && k < nb && k < ar_log.size() && k < aw_log.size(); k++) begin
      b = rem > 16 ? 16 : rem;
      chk({tag, " ar"}, ar_log[k], {sa, 8'(b - 1)});
      chk({tag, " aw"}, aw_log[k], {da, 8'(b - 1)});
      bad = 0;
      for (int i = 0; i < b; i++) begin
        logic [31:0] s_i, d_i;
        s_i = sa + 32'(i * 8);
        d_i = da + 32'(i * 8);
        if (!wmem.exists(d_i) || !smem.exists(s_i)) bad++;
        else if (wmem[d_i] !== smem[s_i]) bad++;
      end
      chk({tag, " data"}, bad, 0);
      sa += 32'(b * 8); da += 32'(b * 8); rem -= b;
    end
  endtask
  task automatic quick(input logic [31:0] s, input logic [31:0] d, input int len, input bit exp_err, input string tag);
    xfer_id++;
    @(negedge clk);
    src_addr = s; dst_addr = d; len_words = 16'(len); start = 1;
    @(negedge clk);
    start = 0;
    chk({tag, " n1"}, {done, busy}, 2'b01);
    @(negedge clk);
    chk({tag, " done_n2"}, done, 1);
    chk({tag, " error"}, error, exp_err);
    @(negedge clk);
    chk({tag, " idle_n3"}, {done, busy}, 0);
    chk({tag, " no_traffic"}, ar_log.size() + aw_log.size(), 0);
  endtask
  initial begin
    vec_t r;
    int wv;
    vecs.push_back('{32'h0000_1000, 32'h8000_0000, 16, 0, 0, 0, 1});
    vecs.push_back('{32'h0000_1000, 32'h8000_2000, 40, 0, 0, 0, 3});
    vecs.push_back('{32'h0000_1000, 32'h8000_4000, 32, 0, 1, 1, 1});
    vecs.push_back('{32'h0000_2000, 32'h8000_6000, 33, 1, 0, 0, 3});
    vecs.push_back('{32'h0000_3008, 32'h9000_0000, 1, 1, 0, 0, 1});
    vecs.push_back('{32'hFFFF_FFC0, 32'h0000_0010, 24, 1, 0, 0, 2});
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, error, bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.rready}, 0);
    chk("reset_addr", {bus.araddr, bus.awaddr, bus.arlen, bus.awlen, bus.wdata}, 0);
    rst_n = 1;
    foreach (vecs[i]) run_xfer(vecs[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 6; i++) begin
      r.src = $urandom & 32'hFFFF_FFF8;
      r.dst = $urandom & 32'hFFFF_FFF8;
      r.len = $urandom_range(1, 50);
      r.stall = $urandom_range(0, 1) == 1;
      r.inj = 0;
      r.exp_err = 0;
      r.exp_b = (r.len + 15) / 16;
      run_xfer(r, $sformatf("rnd%0d", i));
    end
    quick(32'h1000, 32'h8000_0000, 0, 0, "zero_len");
    quick(32'h1004, 32'h8000_0000, 4, 1, "misaligned_src");
    quick(32'h1000, 32'h8000_0003, 4, 1, "misaligned_dst");
    quick(32'h1000, 32'h8000_0000, 0, 0, "error_cleared");
    stall = 0; inj_burst = 0; xfer_id++;
    @(negedge clk);
    src_addr = 32'h5000; dst_addr = 32'h8000_8000; len_words = 16; start = 1;
    @(negedge clk);
    start = 0;
    wv = 0;
    for (int w = 0; w < 500 && wv < 3; w++) begin
      @(negedge clk);
      if (bus.wvalid) wv++;
    end
    chk("rst_reach_wdata", wv, 3);
    rst_n = 0;
    @(negedge clk);
    chk("rst_mid_ctrl", {busy, done, error, bus.arvalid, bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.rready}, 0);
    chk("rst_mid_addr", {bus.araddr, bus.awaddr, bus.arlen, bus.awlen, bus.wdata}, 0);
    rst_n = 1;
    r = '{32'h0000_6000, 32'h8000_9000, 4, 0, 0, 0, 1};
    run_xfer(r, "post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
